// File: rtl/uart_rx_core_if.sv
// Serial receive side of the UART: line input, received word and ready strobe.
// The receiver drives the slave modport; the line driver / host side uses master.
interface uart_rx_core_if #(
    parameter int unsigned data_bits = 8
);
    logic                 rxd;
    logic [data_bits-1:0] RDR;
    logic                 rxd_readyH;

    modport master (
        output rxd,
        input  RDR,
        input  rxd_readyH
    );

    modport slave (
        input  rxd,
        output RDR,
        output rxd_readyH
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver with 16x oversampling and a power-of-two prescaler.
// Delivers each good frame into RDR with a one-cycle rxd_readyH strobe.
module uart_rx_core #(
    parameter int unsigned data_bits                 = 8,
    parameter int unsigned received_bit_counter_bits = 3,
    parameter int unsigned bit_cell_counter_bits     = 4,
    parameter logic [2:0]  br                        = 3'b000
) (
    input logic           sysclk,
    input logic           rst_n,
    uart_rx_core_if.slave rx
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    localparam logic [6:0] tick_mask = 7'((1 << br) - 1);
    localparam logic [bit_cell_counter_bits-1:0] cell_mid  = bit_cell_counter_bits'(7);
    localparam logic [bit_cell_counter_bits-1:0] cell_last = '1;
    localparam logic [received_bit_counter_bits-1:0] bit_last =
        received_bit_counter_bits'(data_bits - 1);

    state_e                                 state_q, state_d;
    logic                                   rs1_q, rs_q;
    logic [6:0]                             presc_q;
    logic                                   tick;
    logic [bit_cell_counter_bits-1:0]       cell_q, cell_d;
    logic [received_bit_counter_bits-1:0]   bit_q, bit_d;
    logic [data_bits-1:0]                   shift_q, shift_d;
    logic [data_bits-1:0]                   rdr_q, rdr_d;
    logic                                   ready_q, ready_d;

    // Synchroniser resets to 1 so reset never looks like a start bit.
    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            rs1_q   <= 1'b1;
            rs_q    <= 1'b1;
            presc_q <= '0;
        end else begin
            rs1_q   <= rx.rxd;
            rs_q    <= rs1_q;
            presc_q <= presc_q + 7'd1;
        end
    end

    assign tick = (presc_q & tick_mask) == 7'd0;

    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StIdle;
            cell_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rdr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rdr_q   <= rdr_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdr_d   = rdr_q;
        ready_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cell_d = '0;
                bit_d  = '0;
                if (!rs_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (cell_q == cell_mid) begin
                        cell_d  = '0;
                        state_d = rs_q ? StIdle : StData;
                    end else begin
                        cell_d = cell_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    // Cell counter wraps to 0 on the sample tick, ready for the next cell.
                    cell_d = cell_q + 1'b1;
                    if (cell_q == cell_last) begin
                        shift_d = {rs_q, shift_q[data_bits-1:1]};
                        if (bit_q == bit_last) begin
                            bit_d   = '0;
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    cell_d = cell_q + 1'b1;
                    if (cell_q == cell_last) begin
                        if (rs_q) begin
                            rdr_d   = shift_q;
                            ready_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StWaitIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                // Hold off until the line recovers so a break is not taken as a start bit.
                if (rs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx.RDR        = rdr_q;
    assign rx.rxd_readyH = ready_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: one receiver at br=000, one at br=001.
module tb_uart_rx_core;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 sysclk = ~sysclk;

    uart_rx_core_if #(.data_bits(8)) bus0 ();
    uart_rx_core_if #(.data_bits(8)) bus1 ();

    uart_rx_core #(.br(3'b000)) dut0 (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .rx    (bus0)
    );

    uart_rx_core #(.br(3'b001)) dut1 (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .rx    (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int pulses0 = 0;
    int pulses1 = 0;
    int last_pulse0 = 0;
    int prev_pulse0 = 0;
    logic prev_rdy0 = 1'b0;
    logic prev_rdy1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge sysclk) cyc <= cyc + 1;

    // Output monitor: every strobe must be one cycle wide and match the scoreboard head.
    always @(negedge sysclk) begin
        if (bus0.rxd_readyH === 1'b1) begin
            check("rdy0_width", 32'(prev_rdy0), 32'd0);
            check("rdy0_expected", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) check("rdr0_data", 32'(bus0.RDR), 32'(exp_q0.pop_front()));
            pulses0++;
            prev_pulse0 = last_pulse0;
            last_pulse0 = cyc;
        end
        prev_rdy0 = bus0.rxd_readyH;
        if (bus1.rxd_readyH === 1'b1) begin
            check("rdy1_width", 32'(prev_rdy1), 32'd0);
            check("rdy1_expected", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) check("rdr1_data", 32'(bus1.RDR), 32'(exp_q1.pop_front()));
            pulses1++;
        end
        prev_rdy1 = bus1.rxd_readyH;
    end

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) bus0.rxd = v;
        else bus1.rxd = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic stop,
                              input int cpb);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        if (stop) begin
            if (sel == 0) exp_q0.push_back(data);
            else exp_q1.push_back(data);
        end
        for (int i = 0; i < 10; i++) begin
            set_rxd(sel, bits[i]);
            repeat (cpb) @(negedge sysclk);
        end
    endtask

    initial begin
        logic [9:0] abort_bits;
        bus0.rxd = 1'b1;
        bus1.rxd = 1'b1;

        // Reset held across the first rising edge, released on the negedge.
        @(negedge sysclk);
        rst_n = 1'b0;
        check("reset_rdr", 32'(bus0.RDR), 32'h00);
        check("reset_ready", 32'(bus0.rxd_readyH), 32'd0);
        repeat (200) @(negedge sysclk);
        check("idle_pulses", 32'(pulses0), 32'd0);
        check("idle_rdr", 32'(bus0.RDR), 32'h00);

        send_frame(0, 8'hA5, 1'b1, 16);
        repeat (20) @(negedge sysclk);
        check("a5_pulses", 32'(pulses0), 32'd1);
        check("a5_rdr", 32'(bus0.RDR), 32'hA5);

        // Short low glitch must be rejected.
        bus0.rxd = 1'b0;
        repeat (4) @(negedge sysclk);
        bus0.rxd = 1'b1;
        repeat (40) @(negedge sysclk);
        check("glitch_pulses", 32'(pulses0), 32'd1);
        check("glitch_rdr", 32'(bus0.RDR), 32'hA5);

        send_frame(0, 8'h3C, 1'b1, 16);
        repeat (20) @(negedge sysclk);
        check("3c_pulses", 32'(pulses0), 32'd2);
        check("3c_rdr", 32'(bus0.RDR), 32'h3C);

        // Framing error: stop bit low, line held low, then released.
        send_frame(0, 8'h55, 1'b0, 16);
        repeat (40) @(negedge sysclk);
        bus0.rxd = 1'b1;
        repeat (20) @(negedge sysclk);
        check("ferr_pulses", 32'(pulses0), 32'd2);
        check("ferr_rdr", 32'(bus0.RDR), 32'h3C);

        send_frame(0, 8'h81, 1'b1, 16);
        repeat (20) @(negedge sysclk);
        check("81_pulses", 32'(pulses0), 32'd3);
        check("81_rdr", 32'(bus0.RDR), 32'h81);

        // Back-to-back frames, no idle gap.
        send_frame(0, 8'h00, 1'b1, 16);
        send_frame(0, 8'hFF, 1'b1, 16);
        repeat (20) @(negedge sysclk);
        check("b2b_pulses", 32'(pulses0), 32'd5);
        check("b2b_spacing", 32'(last_pulse0 - prev_pulse0), 32'd160);
        check("b2b_rdr", 32'(bus0.RDR), 32'hFF);

        // Reset partway through bit 4 of a 0x12 frame.
        abort_bits = {1'b1, 8'h12, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus0.rxd = abort_bits[i];
            repeat (16) @(negedge sysclk);
        end
        bus0.rxd = abort_bits[5];
        repeat (8) @(negedge sysclk);
        rst_n = 1'b1;
        bus0.rxd = 1'b1;
        @(negedge sysclk);
        rst_n = 1'b0;
        check("abort_rdr", 32'(bus0.RDR), 32'h00);
        check("abort_ready", 32'(bus0.rxd_readyH), 32'd0);
        repeat (200) @(negedge sysclk);
        check("abort_pulses", 32'(pulses0), 32'd5);
        check("abort_rdr_late", 32'(bus0.RDR), 32'h00);

        // Prescaler: br=001, 32 cycles per bit.
        send_frame(1, 8'h6E, 1'b1, 32);
        repeat (40) @(negedge sysclk);
        check("br1_pulses", 32'(pulses1), 32'd1);
        check("br1_rdr", 32'(bus1.RDR), 32'h6E);

        check("sb0_drained", 32'(exp_q0.size()), 32'd0);
        check("sb1_drained", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Asynchronous serial receiver (8N1-style, LSB first) with 16x oversampling. It sits behind the board `rxd` pin and delivers each received character as a parallel word plus a one-cycle ready strobe. The strobe goes to the host register interface. A parameterised prescaler sets the baud rate from `sysclk`.

## Interface
- `data_bits`, default 8: number of data bits per frame.
- `received_bit_counter_bits`, default 3: width of the data-bit counter. Requires 2^w >= `data_bits`.
- `bit_cell_counter_bits`, default 4: width of the oversample counter. 2^w = 16 ticks per bit cell.
- `br`, default 3'b000: baud select. Sample-tick period = 2^`br` sysclk cycles, so 000 gives a tick every cycle.
- `sysclk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-high reset. Asserted when 1, despite the name.
- `rxd`, in, 1: serial line. Asynchronous to `sysclk`. Idles high.
- `RDR`, out, `data_bits`: receive data register. Holds the last good frame.
- `rxd_readyH`, out, 1: one-sysclk-cycle high pulse when `RDR` is updated.

## Operation
- **Input sync:** `rxd` passes through a 2-flop synchroniser. All decisions use the synchronised value `rs`.
- **Prescaler:** a 7-bit counter issues a tick every 2^`br` cycles. It runs freely and is cleared by reset.
- **States:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:**
  - `rs`=0 → START, with cell counter cleared.
  - The cell counter and bit counter are held at 0.
- **START:**
  - The cell counter increments on each tick.
  - At count 7 (the 8th tick, mid start bit), sample `rs`.
  - `rs`=0 → DATA, cell counter cleared.
  - `rs`=1 → false start, return to IDLE with no output change.
- **DATA:**
  - The cell counter increments on each tick.
  - At count 15 (16th tick), sample `rs` into the shift register, LSB first (shift right, insert at MSB).
  - The bit counter then increments.
  - After `data_bits` samples → STOP, cell counter cleared.
- **STOP:**
  - At the 16th tick, sample `rs`.
  - `rs`=1: load `RDR` with the shift register, pulse `rxd_readyH` for one sysclk cycle, go to IDLE.
  - `rs`=0: framing error. `RDR` is unchanged, no pulse, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rs`=1, then go to IDLE. This prevents a break condition from being read as a start bit.
- **Counters:** the cell counter wraps modulo 2^`bit_cell_counter_bits`. The bit counter never wraps mid-frame because it resets on entering STOP.
- **Overrun:** `RDR` is overwritten on each good frame. There is no host acknowledge and no overrun flag.
- **Reset:**
  - `RDR`=0, `rxd_readyH`=0.
  - State = IDLE, all counters and the shift register = 0.
  - Synchroniser flops = 1, i.e. idle line.
  - Reset mid-frame aborts the frame with no output.

## Timing
- Timing below is for `br`=000, i.e. one tick per cycle; multiply tick counts by 2^`br` for other settings.
- **Start detection:** `rxd` falling is seen as `rs`=0 two cycles later. That is cycle E, the first cycle in START.
- **Sample points:**
  - Start bit validated at E+7.
  - Data bit k (k = 0..`data_bits`-1) sampled at E+7+16(k+1).
  - Stop bit sampled at E+7+16(`data_bits`+1), which is E+151 for 8 bits.
- **Outputs:** `RDR` and `rxd_readyH` change on the clock edge after the stop sample. For 8 bits that is edge E+152, and `rxd_readyH` deasserts on the next edge.
- **Back-to-back frames:** the design is back in IDLE at the same edge as the ready pulse. A start bit whose falling edge arrives mid-stop-bit-plus-half is still accepted.
- **Baud tolerance:** ±4% overall mismatch.
- **False start:** any low pulse on `rs` shorter than 8 ticks is rejected.

## Test plan
- **Reset:** pulse `rst_n`=1 for 1 cycle with `rxd`=1 → `RDR`=0x00, `rxd_readyH`=0, and no activity for 200 cycles.
- **Single frame, `br`=000:** send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 cycles per bit → exactly one `rxd_readyH` pulse 1 cycle wide, and `RDR`=0xA5 from that edge onward.
- **Glitch:** drive `rxd` low for 4 cycles, then high → no pulse, `RDR` unchanged. A following frame 0x3C is received correctly.
- **Framing error:** send 0x55 with stop bit 0, holding `rxd` low 40 more cycles → no pulse, `RDR` keeps its previous value. The next frame 0x81 after the line returns high → `RDR`=0x81.
- **Back-to-back and reset abort:** two frames 0x00 then 0xFF with no idle gap → two pulses 160 cycles apart, `RDR`=0xFF. Then assert `rst_n` in the middle of a 0x12 frame → `RDR`=0, no pulse.
- **Prescaler:** `br`=001 with 32 cycles per bit, frame 0x6E → `RDR`=0x6E, ready pulse 1 cycle wide.
